// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, FSM encoding and bit-reverse helper for the FFT frame controller.
package fft_pkg;
  localparam int N_POINTS = 4;
  localparam int LOG2N = 2;
  localparam int IN_W = 16;
  localparam int OUT_W = 19;
  typedef enum logic {FILL = 1'b0, FEED = 1'b1} state_t;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = x[LOG2N-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: sample stream, core drive/return and tagged output bundle.
interface fft_frame_ctrl_if;
  import fft_pkg::*;
  logic s_valid;
  logic s_ready;
  logic signed [IN_W-1:0] s_r;
  logic signed [IN_W-1:0] s_i;
  logic signed [IN_W-1:0] core_in_r;
  logic signed [IN_W-1:0] core_in_i;
  logic signed [OUT_W-1:0] core_out_r;
  logic signed [OUT_W-1:0] core_out_i;
  logic m_valid;
  logic m_first;
  logic m_last;
  logic [LOG2N-1:0] m_idx;
  logic signed [OUT_W-1:0] m_r;
  logic signed [OUT_W-1:0] m_i;
  modport master (
    input s_valid, s_r, s_i, core_out_r, core_out_i,
    output s_ready, core_in_r, core_in_i, m_valid, m_first, m_last, m_idx, m_r, m_i
  );
  modport slave (
    output s_valid, s_r, s_i, core_out_r, core_out_i,
    input s_ready, core_in_r, core_in_i, m_valid, m_first, m_last, m_idx, m_r, m_i
  );
endinterface

// File: rtl/fft_bitrev_buf.sv
// fft_bitrev_buf: collects one core-order frame and replays it in natural frequency order.
module fft_bitrev_buf
  import fft_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [LOG2N-1:0] in_pos,
  input  logic signed [OUT_W-1:0] in_r,
  input  logic signed [OUT_W-1:0] in_i,
  output logic out_valid,
  output logic out_first,
  output logic out_last,
  output logic [LOG2N-1:0] out_idx,
  output logic signed [OUT_W-1:0] out_r,
  output logic signed [OUT_W-1:0] out_i
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);
  logic signed [OUT_W-1:0] mem_r [N_POINTS];
  logic signed [OUT_W-1:0] mem_i [N_POINTS];
  logic reading;
  logic [LOG2N-1:0] rd;
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_r[in_pos] <= in_r;
      mem_i[in_pos] <= in_i;
    end
  end
  // Frame spacing guarantees the replay ends before the next frame's first write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reading <= 1'b0;
      rd <= '0;
    end else if (in_valid && in_pos == LAST) begin
      reading <= 1'b1;
      rd <= '0;
    end else if (reading) begin
      reading <= rd != LAST;
      rd <= rd + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      out_idx <= '0;
      out_r <= '0;
      out_i <= '0;
    end else begin
      out_valid <= reading;
      out_first <= reading && rd == '0;
      out_last <= reading && rd == LAST;
      out_idx <= reading ? rd : '0;
      out_r <= reading ? mem_r[bitrev(rd)] : '0;
      out_i <= reading ? mem_i[bitrev(rd)] : '0;
    end
  end
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: buffers one frame, streams it into the FFT core and tags the core outputs.
// Define FFT_BITREV_EN to emit frames in natural frequency order.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int CORE_LATENCY = 3
) (
  input logic clk,
  input logic rst,
  fft_frame_ctrl_if.master bus
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);
  state_t state, state_nx;
  logic [LOG2N-1:0] wr_cnt, rd_cnt, load_idx, in_pos, out_pos;
  logic accept, last_acc, load_en, in_v, out_v;
  logic signed [IN_W-1:0] mem_r [N_POINTS];
  logic signed [IN_W-1:0] mem_i [N_POINTS];
  logic [CORE_LATENCY-1:0] tag_v;
  logic [LOG2N-1:0] tag_pos [CORE_LATENCY];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else state <= state_nx;
  end
  always_comb state_nx = (state == FILL) ? (last_acc ? FEED : FILL) : (rd_cnt == LAST ? FILL : FEED);
  // Sample 0 is loaded on the final accept so the core sees the frame starting the next cycle.
  always_comb begin
    bus.s_ready = (state == FILL) && !rst;
    accept = bus.s_valid && bus.s_ready;
    last_acc = accept && wr_cnt == LAST;
    load_en = last_acc || (state == FEED && rd_cnt != LAST);
    load_idx = (state == FEED) ? rd_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      wr_cnt <= accept ? wr_cnt + 1'b1 : wr_cnt;
      rd_cnt <= (state == FEED) ? rd_cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_r[wr_cnt] <= bus.s_r;
      mem_i[wr_cnt] <= bus.s_i;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.core_in_r <= '0;
      bus.core_in_i <= '0;
      in_v <= 1'b0;
      in_pos <= '0;
    end else begin
      bus.core_in_r <= load_en ? mem_r[load_idx] : '0;
      bus.core_in_i <= load_en ? mem_i[load_idx] : '0;
      in_v <= load_en;
      in_pos <= load_idx;
    end
  end
  // Tags travel beside the core's data so overlapping frames stay distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int j = 0; j < CORE_LATENCY; j++) tag_pos[j] <= '0;
    end else begin
      tag_v[0] <= in_v;
      tag_pos[0] <= in_pos;
      for (int j = 1; j < CORE_LATENCY; j++) begin
        tag_v[j] <= tag_v[j-1];
        tag_pos[j] <= tag_pos[j-1];
      end
    end
  end
  assign out_v = tag_v[CORE_LATENCY-1];
  assign out_pos = tag_pos[CORE_LATENCY-1];
`ifdef FFT_BITREV_EN
  fft_bitrev_buf u_bitrev (
    .clk(clk),
    .rst(rst),
    .in_valid(out_v),
    .in_pos(out_pos),
    .in_r(bus.core_out_r),
    .in_i(bus.core_out_i),
    .out_valid(bus.m_valid),
    .out_first(bus.m_first),
    .out_last(bus.m_last),
    .out_idx(bus.m_idx),
    .out_r(bus.m_r),
    .out_i(bus.m_i)
  );
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_first <= 1'b0;
      bus.m_last <= 1'b0;
      bus.m_idx <= '0;
      bus.m_r <= '0;
      bus.m_i <= '0;
    end else begin
      bus.m_valid <= out_v;
      bus.m_first <= out_v && out_pos == '0;
      bus.m_last <= out_v && out_pos == LAST;
      bus.m_idx <= out_v ? out_pos : '0;
      bus.m_r <= out_v ? bus.core_out_r : '0;
      bus.m_i <= out_v ? bus.core_out_i : '0;
    end
  end
`endif
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench for fft_frame_ctrl with a sign-extending delay-line core model.
module tb_fft_frame_ctrl;
  import fft_pkg::*;
  localparam int LAT = 3;
`ifdef FFT_BITREV_EN
  localparam int EXTRA = 4;
  localparam int ORD[4] = '{0, 2, 1, 3};
`else
  localparam int EXTRA = 0;
  localparam int ORD[4] = '{0, 1, 2, 3};
`endif
  typedef struct {
    int c;
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] i;
    logic f;
    logic l;
    logic [LOG2N-1:0] idx;
  } out_t;
  typedef struct {
    logic [IN_W-1:0] r[4];
    logic [IN_W-1:0] i[4];
    logic [OUT_W-1:0] er[4];
    logic [OUT_W-1:0] ei[4];
  } vec_t;

  logic clk = 0;
  logic rst = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  out_t outs[$];
  int acc_c[$];
  logic [IN_W-1:0] acc_r[$];
  vec_t vt[3];
  logic signed [OUT_W-1:0] dr[LAT];
  logic signed [OUT_W-1:0] di[LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_ctrl_if bus();
  fft_frame_ctrl #(.CORE_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always @(posedge clk) begin
    dr[0] <= {{(OUT_W-IN_W){bus.core_in_r[IN_W-1]}}, bus.core_in_r};
    di[0] <= {{(OUT_W-IN_W){bus.core_in_i[IN_W-1]}}, bus.core_in_i};
    for (int j = 1; j < LAT; j++) begin
      dr[j] <= dr[j-1];
      di[j] <= di[j-1];
    end
  end
  assign bus.core_out_r = dr[LAT-1];
  assign bus.core_out_i = di[LAT-1];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_valid && bus.s_ready) begin
        acc_c.push_back(cyc);
        acc_r.push_back(bus.s_r);
      end
      if (bus.m_valid) outs.push_back('{cyc, bus.m_r, bus.m_i, bus.m_first, bus.m_last, bus.m_idx});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] r, input logic [IN_W-1:0] i);
    logic rdy;
    int t;
    bus.s_valid = 1;
    bus.s_r = r;
    bus.s_i = i;
    t = 0;
    do begin
      @(negedge clk);
      rdy = bus.s_ready;
      step();
      t++;
    end while (!rdy && t < 50);
    if (!rdy) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (outs.size() < n && t < 80) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("out_count", outs.size(), n);
  endtask

  task automatic clear_logs();
    outs.delete();
    acc_c.delete();
    acc_r.delete();
  endtask

  task automatic run_vec(input int v);
    int t;
    clear_logs();
    for (int k = 0; k < 4; k++) send(vt[v].r[k], vt[v].i[k]);
    bus.s_valid = 0;
    chk("acc_count", acc_c.size(), 4);
    t = acc_c.size() > 0 ? acc_c[$] : 0;
    wait_outs(4);
    if (outs.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_cyc%0d", v, k), outs[k].c, t + 5 + EXTRA + k);
        chk($sformatf("v%0d_r%0d", v, k), outs[k].r, vt[v].er[ORD[k]]);
        chk($sformatf("v%0d_i%0d", v, k), outs[k].i, vt[v].ei[ORD[k]]);
        chk($sformatf("v%0d_idx%0d", v, k), outs[k].idx, k);
        chk($sformatf("v%0d_first%0d", v, k), outs[k].f, k == 0);
        chk($sformatf("v%0d_last%0d", v, k), outs[k].l, k == 3);
      end
    end
  endtask

  initial begin
    logic [IN_W-1:0] b2b[8];
    int t, nz;
    b2b = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
    vt[0] = '{'{16'h0000, 16'h0100, 16'h0200, 16'h0300}, '{16'h0000, 16'h0100, 16'h0200, 16'h0300},
              '{19'h00000, 19'h00100, 19'h00200, 19'h00300}, '{19'h00000, 19'h00100, 19'h00200, 19'h00300}};
    vt[1] = '{'{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF}, '{16'h1234, 16'hFEDC, 16'h8001, 16'h0000},
              '{19'h78000, 19'h07FFF, 19'h00001, 19'h7FFFF}, '{19'h01234, 19'h7FEDC, 19'h78001, 19'h00000}};
    vt[2] = '{'{16'h4000, 16'hC000, 16'h0055, 16'hFF00}, '{16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0},
              '{19'h04000, 19'h7C000, 19'h00055, 19'h7FF00}, '{19'h7AAAA, 19'h05555, 19'h00F0F, 19'h7F0F0}};
    bus.s_valid = 0;
    bus.s_r = '0;
    bus.s_i = '0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_core_in_r", $unsigned(bus.core_in_r), 0);
    chk("rst_core_in_i", $unsigned(bus.core_in_i), 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_r", $unsigned(bus.m_r), 0);
    chk("rst_m_first", bus.m_first, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_idx", bus.m_idx, 0);
    step();
    rst = 0;
    #1;
    chk("post_rst_s_ready", bus.s_ready, 1);
    step();

    for (int v = 0; v < 3; v++) run_vec(v);

    // Back-to-back frames with s_valid held through FEED
    clear_logs();
    for (int j = 0; j < 8; j++) send(b2b[j], b2b[j]);
    bus.s_valid = 0;
    wait_outs(8);
    chk("b2b_acc_count", acc_c.size(), 8);
    if (acc_c.size() == 8) begin
      for (int j = 0; j < 8; j++) chk($sformatf("b2b_acc%0d", j), acc_r[j], b2b[j]);
      chk("b2b_burst1", acc_c[3] - acc_c[0], 3);
      chk("b2b_ready_gap", acc_c[4] - acc_c[3], 5);
    end
    if (outs.size() == 8) begin
      chk("b2b_frame_spacing", outs[4].c - outs[0].c, 8);
      chk("b2b_f2_first_r", outs[4].r, 19'h00055);
      chk("b2b_f2_first_flag", outs[4].f, 1);
      chk("b2b_f2_last_r", outs[7].r, 19'h00088);
    end

    // Gap after two samples: core must stay idle until the frame completes
    clear_logs();
    send(16'h1111, 16'h0101);
    send(16'h2222, 16'h0202);
    bus.s_valid = 0;
    nz = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.core_in_r != 0 || bus.core_in_i != 0) nz++;
    end
    chk("gap_core_idle", nz, 0);
    chk("gap_ready_held", bus.s_ready, 1);
    step();
    send(16'h3333, 16'h0303);
    send(16'h4444, 16'h0404);
    bus.s_valid = 0;
    chk("gap_core_in_first", $unsigned(bus.core_in_r), 32'h1111);
    t = acc_c.size() > 0 ? acc_c[$] : 0;
    wait_outs(4);
    if (outs.size() == 4) begin
      chk("gap_out_cyc0", outs[0].c, t + 5 + EXTRA);
      chk("gap_out_r0", outs[0].r, 19'h01111);
      chk("gap_out_cyc3", outs[3].c, t + 8 + EXTRA);
      chk("gap_out_i3", outs[3].i, 19'h00404);
    end

    // Reset in the middle of FEED
    clear_logs();
    for (int k = 0; k < 4; k++) send(vt[1].r[k], vt[1].i[k]);
    bus.s_valid = 0;
    step();
    rst = 1;
    #1;
    chk("midrst_core_in_r", $unsigned(bus.core_in_r), 0);
    chk("midrst_core_in_i", $unsigned(bus.core_in_i), 0);
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_wr_cnt", dut.wr_cnt, 0);
    chk("midrst_rd_cnt", dut.rd_cnt, 0);
    step();
    rst = 0;
    #1;
    chk("midrst_ready_after", bus.s_ready, 1);
    outs.delete();
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_no_stale", outs.size(), 0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
